dm_responder: RTL and testbench

- Data-memory responder: the slave end of the memory-stage load/store request channel issued by the pipelined CPU.
- Accepts one request at a time over a valid/ready handshake and returns a response after a parameterised number of wait states.
- Writes respect byte enables; reads return the full aligned word, and the memory stage extracts the sub-word.
- Lets the pipeline hazard unit be exercised against a multi-cycle memory instead of a single-cycle array.

---
 rtl/dm_responder_pkg.sv | 20 ++
 rtl/dm_be_merge.sv | 19 +
 rtl/dm_responder.sv | 140 ++++++++++++++
 tb/tb_dm_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: FSM encodings, legal byte-enable patterns and default sizing shared by the responder and CPU store path
package dm_responder_pkg;
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;
  localparam logic [3:0] DM_BE_B0 = 4'b0001;
  localparam logic [3:0] DM_BE_B1 = 4'b0010;
  localparam logic [3:0] DM_BE_B2 = 4'b0100;
  localparam logic [3:0] DM_BE_B3 = 4'b1000;
  localparam logic [3:0] DM_BE_H0 = 4'b0011;
  localparam logic [3:0] DM_BE_H1 = 4'b1100;
  localparam logic [3:0] DM_BE_W  = 4'b1111;
  localparam int DM_ADDR_W_DEF = 12;
  localparam int DM_WAIT_DEF   = 2;
  function automatic logic dm_be_legal(input logic [3:0] be);
    return be inside {DM_BE_B0, DM_BE_B1, DM_BE_B2, DM_BE_B3, DM_BE_H0, DM_BE_H1, DM_BE_W};
  endfunction
endpackage

// File: rtl/dm_be_merge.sv
// dm_be_merge: merges lane-aligned store data into the old word under byte enables and flags illegal enable patterns
module dm_be_merge
  import dm_responder_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged,
  output logic        o_legal
);
  // pick each byte lane from the store data when enabled, otherwise keep the old byte
  always_comb begin
    o_merged = {i_be[3] ? i_wdata[31:24] : i_old[31:24],
                i_be[2] ? i_wdata[23:16] : i_old[23:16],
                i_be[1] ? i_wdata[15:8]  : i_old[15:8],
                i_be[0] ? i_wdata[7:0]   : i_old[7:0]};
    o_legal  = dm_be_legal(i_be);
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory slave with byte-enable stores; define DM_DISPLAY_EN to print every successful store
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W_DEF,
  parameter int WAIT   = DM_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  dm_state_t r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_pc;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [2**ADDR_W-1:0] r_vld;
  logic              w_acc, w_go_resp, w_live, w_in_oor;
  logic              w_s_we, w_s_oor, w_legal, w_err, w_write;
  logic [ADDR_W-1:0] w_s_addr;
  logic [3:0]        w_s_be;
  logic [31:0]       w_s_wdata, w_s_pc, w_old, w_merged;
  logic              w_unused;

  assign w_in_oor = |req_addr[31:ADDR_W+2];
  assign w_live    = r_state == DM_IDLE;
  assign w_s_we    = w_live ? req_we : r_we;
  assign w_s_oor   = w_live ? w_in_oor : r_oor;
  assign w_s_addr  = w_live ? req_addr[ADDR_W+1:2] : r_addr;
  assign w_s_be    = w_live ? req_be : r_be;
  assign w_s_wdata = w_live ? req_wdata : r_wdata;
  assign w_s_pc    = w_live ? req_pc : r_pc;
  assign w_old     = r_vld[w_s_addr] ? r_mem[w_s_addr] : '0;
  assign w_err     = !w_legal || w_s_oor;
  assign w_write   = reset && w_go_resp && w_s_we && !w_err;
  assign w_unused  = ^{req_addr[1:0], w_s_pc};
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  dm_be_merge u_merge (
    .i_old    (w_old),
    .i_wdata  (w_s_wdata),
    .i_be     (w_s_be),
    .o_merged (w_merged),
    .o_legal  (w_legal)
  );

  // next state, handshake outputs and the RESP-entry strobe that commits the access
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_acc      = 1'b0;
    w_go_resp  = 1'b0;
    case (r_state)
      DM_IDLE: begin
        req_ready = 1'b1;
        w_acc     = req_valid;
        w_go_resp = req_valid && (WAIT == 0);
        if (req_valid) w_next = (WAIT == 0) ? DM_RESP : DM_BUSY;
      end
      DM_BUSY: begin
        w_go_resp = r_cnt == 4'd1;
        if (w_go_resp) w_next = DM_RESP;
      end
      DM_RESP: begin
        resp_valid = 1'b1;
        w_next     = DM_IDLE;
      end
      default: w_next = DM_IDLE;
    endcase
  end

  // state register, wait counter and request capture at the acceptance edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DM_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cnt   <= 4'(WAIT);
        r_we    <= req_we;
        r_oor   <= w_in_oor;
        r_addr  <= req_addr[ADDR_W+1:2];
        r_be    <= req_be;
        r_wdata <= req_wdata;
        r_pc    <= req_pc;
      end else if (r_state == DM_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // response data and error, nonzero only during the RESP cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= (w_go_resp && !w_s_we && !w_err) ? w_old : '0;
      r_err   <= w_go_resp && w_err;
    end
  end

  // per-word written flags; clearing them makes the whole memory read as zero after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld <= '0;
    else if (w_write) r_vld[w_s_addr] <= 1'b1;
  end

  // storage array, written only on the RESP-entry edge of a legal store
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_s_addr] <= w_merged;
`ifdef DM_DISPLAY_EN
      $display("@%h: *%h <= %h", w_s_pc, 32'({w_s_addr, 2'b00}), w_merged);
`endif
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a word-array reference model
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        v[2], we[2], rdy[2], rv[2], er[2];
  logic [31:0] addr[2], wd[2], pc[2], rd[2];
  logic [3:0]  be[2];
  logic [31:0] mdl [2][4096];
  int          wt[2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(12), .WAIT(2)) dut (
    .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_be(be[0]), .req_wdata(wd[0]), .req_pc(pc[0]),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dm_responder #(.ADDR_W(12), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_be(be[1]), .req_wdata(wd[1]), .req_pc(pc[1]),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4096; i++) mdl[d][i] = '0;
  endtask

  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] dt, output logic [31:0] erd, output logic eerr);
    logic [11:0] wa;
    wa   = a[13:2];
    eerr = !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) || (a[31:14] != 0);
    erd  = '0;
    if (!eerr && w)
      for (int i = 0; i < 4; i++) if (b[i]) mdl[d][wa][8*i +: 8] = dt[8*i +: 8];
    if (!eerr && !w) erd = mdl[d][wa];
  endtask

  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] dt, input string tag);
    logic [31:0] erd;
    logic        eerr;
    int          n;
    int          lat;
    model(d, w, a, b, dt, erd, eerr);
    @(negedge clk);
    v[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wd[d] = dt; pc[d] = $urandom;
    n = 0;
    while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
    chk({tag, "/idle_ready"}, 32'(rdy[d]), 32'd1);
    @(negedge clk);
    v[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; be[d] = 4'($urandom); wd[d] = $urandom;
    chk({tag, "/busy_ready"}, 32'(rdy[d]), 32'd0);
    lat = 0;
    while (!rv[d] && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "/latency"}, 32'(lat), 32'(wt[d]));
    chk({tag, "/rdata"}, rd[d], erd);
    chk({tag, "/err"}, 32'(er[d]), 32'(eerr));
    @(negedge clk);
    chk({tag, "/pulse"}, 32'(rv[d]), 32'd0);
    chk({tag, "/idle_rdata"}, rd[d] | 32'(er[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] qa[3];
    logic [3:0]  lb[7];
    int          acc[3];
    int          k, got;
    logic        pend;
    logic [31:0] a;
    logic [3:0]  b;
    int          d;
    wt[0] = 2; wt[1] = 0;
    lb = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    qa = '{32'h40, 32'h44, 32'h48};
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wd[i] = '0; pc[i] = '0;
    end
    clear_model();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset/ready", 32'(rdy[i]), 32'd1);
      chk("reset/valid", 32'(rv[i]), 32'd0);
      chk("reset/rdata", rd[i], 32'd0);
      chk("reset/err", 32'(er[i]), 32'd0);
    end
    reset = 1'b1;

    xact(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, "sw");
    xact(0, 1'b0, 32'h10, 4'b1111, 32'h0, "lw1");
    chk("lw1/const", mdl[0][4], 32'hDEADBEEF);
    xact(0, 1'b1, 32'h10, 4'b0100, 32'h00AB0000, "sb");
    xact(0, 1'b0, 32'h10, 4'b1111, 32'h0, "lw2");
    xact(0, 1'b1, 32'h10, 4'b0011, 32'h00001234, "sh");
    xact(0, 1'b0, 32'h10, 4'b1111, 32'h0, "lw3");
    xact(0, 1'b1, 32'h10, 4'b0101, 32'h55555555, "bad_be");
    xact(0, 1'b1, 32'h4000, 4'b1111, 32'h66666666, "oor");
    xact(0, 1'b0, 32'h4000, 4'b1111, 32'h0, "oor_ld");
    xact(0, 1'b1, 32'h10, 4'b0000, 32'h77777777, "zero_be");
    xact(0, 1'b0, 32'h10, 4'b1111, 32'h0, "lw4");

    for (int i = 0; i < 3; i++) xact(0, 1'b1, qa[i], 4'b1111, $urandom, "pre");
    @(negedge clk);
    v[0] = 1'b1; we[0] = 1'b0; be[0] = 4'b1111; addr[0] = qa[0];
    k = 0; got = 0; pend = 1'b0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (pend) begin
        pend = 1'b0;
        if (k < 3) addr[0] = qa[k];
        else v[0] = 1'b0;
      end
      if (rv[0]) begin
        chk("queue/rdata", rd[0], mdl[0][qa[got][13:2]]);
        got++;
      end
      if (rdy[0] && v[0] && k < 3) begin
        acc[k] = c; k++; pend = 1'b1;
      end
      @(negedge clk);
    end
    v[0] = 1'b0;
    chk("queue/count", 32'(got), 32'd3);
    chk("queue/gap1", 32'(acc[1] - acc[0]), 32'(wt[0] + 2));
    chk("queue/gap2", 32'(acc[2] - acc[1]), 32'(wt[0] + 2));

    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 1));
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h4000 << $urandom_range(0, 17));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : lb[$urandom_range(0, 6)];
      xact(d, 1'($urandom), a, b, $urandom, "rand");
    end

    xact(1, 1'b1, 32'h8, 4'b1111, 32'h11, "w0_sw");
    xact(1, 1'b0, 32'h8, 4'b1111, 32'h0, "w0_lw");

    @(negedge clk);
    v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'b1111; wd[0] = 32'hCAFEF00D;
    @(negedge clk);
    v[0] = 1'b0;
    chk("midrst/busy", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst/ready", 32'(rdy[0]), 32'd1);
    chk("midrst/valid", 32'(rv[0]), 32'd0);
    chk("midrst/rdata", rd[0], 32'd0);
    chk("midrst/err", 32'(er[0]), 32'd0);
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    xact(0, 1'b0, 32'h20, 4'b1111, 32'h0, "midrst_rd");
    xact(0, 1'b0, 32'h10, 4'b1111, 32'h0, "cleared_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
